dmadd_seq: RTL

Command sequencer for the DMADD min/max/madd datapath. Accepts one command (mode plus a stream of index/data load beats) and drives the datapath's reset/insn/load/run pins through clear, init, load and run phases. Captures the 12-bit result and returns it on a valid/ready result port. Sits between the host-side command interface and a single DMADD instance.

---
 rtl/dmadd_pkg.sv | 34 +++
 rtl/dmadd_seq_timer.sv | 28 ++
 rtl/dmadd_seq.sv | 200 ++++++++++++++++++++
 3 files changed

// File: rtl/dmadd_pkg.sv
// Shared types for the DMADD command sequencer: command modes, datapath insn
// encodings, sequencer states and result width.
package dmadd_pkg;

    typedef enum logic [1:0] {
        MODE_MIN     = 2'b00,
        MODE_MAX     = 2'b01,
        MODE_MADD    = 2'b10,
        MODE_ILLEGAL = 2'b11
    } mode_e;

    localparam logic [1:0] INSN_MIN  = 2'b00;
    localparam logic [1:0] INSN_MAX  = 2'b01;
    localparam logic [1:0] INSN_MADD = 2'b10;

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_CLEAR   = 3'd1,
        S_INIT    = 3'd2,
        S_LOAD    = 3'd3,
        S_RUN     = 3'd4,
        S_CAPTURE = 3'd5,
        S_RESP    = 3'd6
    } state_e;

    localparam int RESULT_W = 12;
    localparam int TMR_W    = 6;

    // MAX and MADD both scan the index space downward, so they share an init insn.
    function automatic logic [1:0] init_insn(input mode_e mode);
        return (mode == MODE_MIN) ? INSN_MIN : INSN_MAX;
    endfunction

endpackage

// File: rtl/dmadd_seq_timer.sv
// Loadable 6-bit down-counter with zero flag; times both the run phase and
// the idle gap between load beats.
module dmadd_seq_timer
    import dmadd_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             load_i,
    input  logic [TMR_W-1:0] load_val_i,
    input  logic             dec_i,
    output logic             zero_o
);

    logic [TMR_W-1:0] cnt_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else if (load_i) begin
            cnt_q <= load_val_i;
        end else if (dec_i && (cnt_q != '0)) begin
            cnt_q <= cnt_q - TMR_W'(1);
        end
    end

    assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/dmadd_seq.sv
// Command sequencer for one DMADD datapath: clear, init, load, run, capture, respond.
// Optional load-beat timeout is enabled by defining DMADD_SEQ_TIMEOUT_EN.
module dmadd_seq
    import dmadd_pkg::*;
#(
    parameter int RUN_CYCLES   = 18,
    parameter int LOAD_TIMEOUT = 64
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                cmd_valid,
    output logic                cmd_ready,
    input  logic [1:0]          cmd_mode,
    input  logic                cmd_noload,
    input  logic                ld_valid,
    output logic                ld_ready,
    input  logic [3:0]          ld_index,
    input  logic [3:0]          ld_data,
    input  logic                ld_last,
    output logic                dp_rst_n,
    output logic [3:0]          dp_index,
    output logic [3:0]          dp_data,
    output logic [1:0]          dp_insn,
    output logic                dp_load,
    output logic                dp_run,
    input  logic [7:0]          dp_out,
    input  logic [3:0]          dp_out_top,
    output logic                res_valid,
    input  logic                res_ready,
    output logic [RESULT_W-1:0] res_value,
    output logic                res_err,
    output logic                busy,
    output state_e              dbg_state
);

    localparam logic [TMR_W-1:0] RUN_LOAD = TMR_W'(RUN_CYCLES - 1);
    localparam logic [TMR_W-1:0] TO_LOAD  = TMR_W'(LOAD_TIMEOUT - 1);

    state_e              state_q, state_d;
    mode_e               mode_q, mode_d;
    logic                noload_q, noload_d;
    logic [RESULT_W-1:0] res_value_q, res_value_d;
    logic                res_err_q, res_err_d;
    logic                dp_rst_n_q, dp_rst_n_d;
    logic [3:0]          dp_index_q, dp_index_d;
    logic [3:0]          dp_data_q, dp_data_d;
    logic [1:0]          dp_insn_q, dp_insn_d;
    logic                dp_load_q, dp_load_d;
    logic                dp_run_q, dp_run_d;

    logic                tmr_load, tmr_dec, tmr_zero;
    logic [TMR_W-1:0]    tmr_val;

    dmadd_seq_timer u_timer (
        .clk       (clk),
        .rst       (rst),
        .load_i    (tmr_load),
        .load_val_i(tmr_val),
        .dec_i     (tmr_dec),
        .zero_o    (tmr_zero)
    );

    // All three ports are valid/ready: a transfer happens on a rising edge where
    // both are high; the producer holds its payload steady until then.
    assign cmd_ready = (state_q == S_IDLE);
    assign ld_ready  = (state_q == S_LOAD);
    assign res_valid = (state_q == S_RESP);
    assign busy      = (state_q != S_IDLE);
    assign dbg_state = state_q;

    always_comb begin
        state_d     = state_q;
        mode_d      = mode_q;
        noload_d    = noload_q;
        res_value_d = res_value_q;
        res_err_d   = res_err_q;
        dp_rst_n_d  = dp_rst_n_q;
        dp_index_d  = dp_index_q;
        dp_data_d   = dp_data_q;
        dp_insn_d   = dp_insn_q;
        dp_load_d   = 1'b0;
        dp_run_d    = 1'b0;
        tmr_load    = 1'b0;
        tmr_val     = '0;
        tmr_dec     = 1'b0;

        case (state_q)
            S_IDLE: begin
                dp_rst_n_d = 1'b0;
                dp_index_d = '0;
                dp_data_d  = '0;
                dp_insn_d  = '0;
                if (cmd_valid) begin
                    mode_d      = mode_e'(cmd_mode);
                    noload_d    = cmd_noload;
                    res_value_d = '0;
                    res_err_d   = (mode_e'(cmd_mode) == MODE_ILLEGAL);
                    state_d     = (mode_e'(cmd_mode) == MODE_ILLEGAL) ? S_RESP : S_CLEAR;
                end
            end
            S_CLEAR: begin
                dp_rst_n_d = 1'b0;
                state_d    = S_INIT;
            end
            S_INIT: begin
                dp_rst_n_d = 1'b1;
                dp_insn_d  = init_insn(mode_q);
                tmr_load   = 1'b1;
                tmr_val    = noload_q ? RUN_LOAD : TO_LOAD;
                state_d    = noload_q ? S_RUN : S_LOAD;
            end
            S_LOAD: begin
                if (ld_valid) begin
                    dp_load_d  = 1'b1;
                    dp_index_d = ld_index;
                    dp_data_d  = ld_data;
                    dp_insn_d  = (mode_q == MODE_MADD) ? INSN_MADD : INSN_MIN;
                    tmr_load   = 1'b1;
                    tmr_val    = ld_last ? RUN_LOAD : TO_LOAD;
                    if (ld_last) begin
                        state_d = S_RUN;
                    end
                end else begin
                    dp_insn_d = init_insn(mode_q);
`ifdef DMADD_SEQ_TIMEOUT_EN
                    if (tmr_zero) begin
                        res_err_d   = 1'b1;
                        res_value_d = '0;
                        dp_rst_n_d  = 1'b0;
                        state_d     = S_RESP;
                    end else begin
                        tmr_dec = 1'b1;
                    end
`endif
                end
            end
            S_RUN: begin
                dp_run_d  = 1'b1;
                dp_insn_d = mode_q;
                tmr_dec   = 1'b1;
                if (tmr_zero) begin
                    state_d = S_CAPTURE;
                end
            end
            S_CAPTURE: begin
                res_value_d = {dp_out_top, dp_out};
                res_err_d   = 1'b0;
                state_d     = S_RESP;
            end
            S_RESP: begin
                if (res_ready) begin
                    dp_rst_n_d = 1'b0;
                    dp_index_d = '0;
                    dp_data_d  = '0;
                    dp_insn_d  = '0;
                    state_d    = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_IDLE;
            mode_q      <= MODE_MIN;
            noload_q    <= 1'b0;
            res_value_q <= '0;
            res_err_q   <= 1'b0;
            dp_rst_n_q  <= 1'b0;
            dp_index_q  <= '0;
            dp_data_q   <= '0;
            dp_insn_q   <= '0;
            dp_load_q   <= 1'b0;
            dp_run_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            mode_q      <= mode_d;
            noload_q    <= noload_d;
            res_value_q <= res_value_d;
            res_err_q   <= res_err_d;
            dp_rst_n_q  <= dp_rst_n_d;
            dp_index_q  <= dp_index_d;
            dp_data_q   <= dp_data_d;
            dp_insn_q   <= dp_insn_d;
            dp_load_q   <= dp_load_d;
            dp_run_q    <= dp_run_d;
        end
    end

    assign res_value = res_value_q;
    assign res_err   = res_err_q;
    assign dp_rst_n  = dp_rst_n_q;
    assign dp_index  = dp_index_q;
    assign dp_data   = dp_data_q;
    assign dp_insn   = dp_insn_q;
    assign dp_load   = dp_load_q;
    assign dp_run    = dp_run_q;

endmodule
